// File: rtl/ps2_key_event_decoder_if.sv
// ps2_key_event_decoder_if: keyboard byte intake and event FIFO handshake
interface ps2_key_event_decoder_if;
  logic [7:0] kb_data;
  logic kb_ready;
  logic kb_overflow;
  logic kb_nextdata_n;
  logic ev_valid;
  logic ev_ready;
  logic [23:0] ev_data;
  modport master (output kb_data, kb_ready, kb_overflow, ev_ready, input kb_nextdata_n, ev_valid, ev_data);
  modport slave (input kb_data, kb_ready, kb_overflow, ev_ready, output kb_nextdata_n, ev_valid, ev_data);
endinterface

// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder: PS/2 scan bytes to press/release events with ASCII, repeat filter and event FIFO
module ps2_key_event_decoder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DROP_W = 4,
  parameter bit REPEAT_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  ps2_key_event_decoder_if.slave bus,
  output logic key_held_o,
  output logic [8:0] held_code_o,
  output logic [CNT_W-1:0] press_count_o,
  output logic [DROP_W-1:0] drop_count_o,
  output logic err_overflow_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;
  state_t state_q, state_d;
  logic nd_q, take, proc, ovf_q;
  logic [7:0] byte_q;
  logic shift_q, shift_d, caps_q, caps_d, held_q, held_d, err_q, err_d;
  logic [8:0] hc_q, hc_d;
  logic [CNT_W-1:0] pc_q, pc_d;
  logic [DROP_W-1:0] dc_q, dc_d;
  logic emit, ext, brk, rpt, is_shift, is_caps, is_mod, push, pop, full, wr;
  logic [23:0] ev;
  logic [23:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;

  function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic up);
    logic [4:0] l;
    logic hit;
    logic [7:0] a;
    l = 5'd0;
    hit = 1'b1;
    a = 8'h00;
    case (c)
      8'h1C: l = 5'd0;  8'h32: l = 5'd1;  8'h21: l = 5'd2;  8'h23: l = 5'd3;
      8'h24: l = 5'd4;  8'h2B: l = 5'd5;  8'h34: l = 5'd6;  8'h33: l = 5'd7;
      8'h43: l = 5'd8;  8'h3B: l = 5'd9;  8'h42: l = 5'd10; 8'h4B: l = 5'd11;
      8'h3A: l = 5'd12; 8'h31: l = 5'd13; 8'h44: l = 5'd14; 8'h4D: l = 5'd15;
      8'h15: l = 5'd16; 8'h2D: l = 5'd17; 8'h1B: l = 5'd18; 8'h2C: l = 5'd19;
      8'h3C: l = 5'd20; 8'h2A: l = 5'd21; 8'h1D: l = 5'd22; 8'h22: l = 5'd23;
      8'h35: l = 5'd24; 8'h1A: l = 5'd25;
      default: hit = 1'b0;
    endcase
    case (c)
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39; 8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return hit ? (up ? 8'h41 : 8'h61) + {3'b000, l} : a;
  endfunction

  // the strobe cycle is also the decode cycle for the byte just latched
  assign take = bus.kb_ready & nd_q;
  assign proc = ~nd_q;
  assign bus.kb_nextdata_n = nd_q;

  always_ff @(posedge clk) begin
    if (take) begin
      byte_q <= bus.kb_data;
      ovf_q <= bus.kb_overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nd_q <= 1'b1;
      state_q <= IDLE;
      shift_q <= 1'b0;
      caps_q <= 1'b0;
      held_q <= 1'b0;
      hc_q <= '0;
      pc_q <= '0;
      dc_q <= '0;
      err_q <= 1'b0;
    end else begin
      nd_q <= ~take;
      state_q <= state_d;
      shift_q <= shift_d;
      caps_q <= caps_d;
      held_q <= held_d;
      hc_q <= hc_d;
      pc_q <= pc_d;
      dc_q <= dc_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    emit = 1'b0;
    ext = 1'b0;
    brk = 1'b0;
    if (proc) begin
      if (ovf_q) state_d = IDLE;
      else case (state_q)
        IDLE: begin
          state_d = byte_q == 8'hE0 ? EXT : byte_q == 8'hF0 ? BRK : IDLE;
          emit = !(byte_q inside {8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hEE, 8'hFE});
        end
        EXT: begin
          state_d = byte_q == 8'hF0 ? EXTBRK : byte_q == 8'hE0 ? EXT : IDLE;
          emit = !(byte_q inside {8'hE0, 8'hF0});
          ext = 1'b1;
        end
        BRK: begin
          state_d = IDLE;
          emit = 1'b1;
          brk = 1'b1;
        end
        default: begin
          state_d = IDLE;
          emit = 1'b1;
          brk = 1'b1;
          ext = 1'b1;
        end
      endcase
    end
  end

  assign is_shift = ~ext & (byte_q == 8'h12 || byte_q == 8'h59);
  assign is_caps = ~ext & (byte_q == 8'h58);
  assign is_mod = is_shift | is_caps;
  assign rpt = ~brk & held_q & (hc_q == {ext, byte_q});
  assign push = emit & (~rpt | REPEAT_EN);
  assign ev = {rpt, brk, ext, caps_q, shift_q, 3'b000, ext ? 8'h00 : to_ascii(byte_q, shift_q ^ caps_q), byte_q};

  always_comb begin
    shift_d = shift_q;
    caps_d = caps_q;
    held_d = held_q;
    hc_d = hc_q;
    pc_d = pc_q;
    err_d = err_q | (proc & ovf_q);
    dc_d = (push & ~wr & ~&dc_q) ? dc_q + DROP_W'(1) : dc_q;
    if (emit) begin
      if (is_shift) shift_d = ~brk;
      if (is_caps & ~brk & ~rpt) caps_d = ~caps_q;
      if (~is_mod & ~brk & ~rpt) begin
        held_d = 1'b1;
        hc_d = {ext, byte_q};
        pc_d = pc_q + CNT_W'(1);
      end
      if (~is_mod & brk & (hc_q == {ext, byte_q})) held_d = 1'b0;
    end
  end

  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign bus.ev_valid = cnt_q != '0;
  assign bus.ev_data = mem_q[rp_q];
  assign pop = bus.ev_valid & bus.ev_ready;
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign wr = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= ev;
  end

  assign key_held_o = held_q;
  assign held_code_o = hc_q;
  assign press_count_o = pc_q;
  assign drop_count_o = dc_q;
  assign err_overflow_o = err_q;
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// tb_ps2_key_event_decoder: table-driven scan sequences with an event scoreboard plus FIFO, repeat, overflow and reset corners
module tb_ps2_key_event_decoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_key_event_decoder_if i0 ();
  ps2_key_event_decoder_if i1 ();
  logic held0, held1, err0, err1;
  logic [8:0] hc0, hc1;
  logic [7:0] pc0, pc1;
  logic [3:0] dc0, dc1;

  ps2_key_event_decoder #(.FIFO_DEPTH(4), .REPEAT_EN(1'b0)) u0 (
    .clk(clk), .rst(rst), .bus(i0), .key_held_o(held0), .held_code_o(hc0),
    .press_count_o(pc0), .drop_count_o(dc0), .err_overflow_o(err0));
  ps2_key_event_decoder #(.FIFO_DEPTH(8), .REPEAT_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .bus(i1), .key_held_o(held1), .held_code_o(hc1),
    .press_count_o(pc1), .drop_count_o(dc1), .err_overflow_o(err1));

  typedef struct {
    logic [7:0] b;
    bit p;
    logic [23:0] e;
    bit h;
    logic [8:0] c;
    logic [7:0] n;
  } vec_t;
  vec_t tv[$];
  logic [23:0] sb[$];
  int total = 0;
  int bad = 0;

  function automatic logic [23:0] ev(bit r, bit b, bit e, bit c, bit s, logic [7:0] a, logic [7:0] k);
    return {r, b, e, c, s, 3'b000, a, k};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic add(input logic [7:0] b, input bit p, input logic [23:0] e, input bit h, input logic [8:0] c, input logic [7:0] n);
    tv.push_back('{b, p, e, h, c, n});
  endtask

  task automatic send(input bit u, input logic [7:0] b, input bit ovf);
    @(posedge clk); #1;
    if (u) begin
      i1.kb_data = b; i1.kb_overflow = ovf; i1.kb_ready = 1'b1;
    end else begin
      i0.kb_data = b; i0.kb_overflow = ovf; i0.kb_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("strobe_low", u ? i1.kb_nextdata_n : i0.kb_nextdata_n, 0);
    i0.kb_ready = 1'b0; i1.kb_ready = 1'b0; i0.kb_overflow = 1'b0; i1.kb_overflow = 1'b0;
    @(posedge clk); #1;
    chk("strobe_high", u ? i1.kb_nextdata_n : i0.kb_nextdata_n, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic chk_reset();
    chk("rst_nextdata_n", i0.kb_nextdata_n, 1);
    chk("rst_ev_valid", i0.ev_valid, 0);
    chk("rst_key_held", held0, 0);
    chk("rst_held_code", hc0, 0);
    chk("rst_press_count", pc0, 0);
    chk("rst_drop_count", dc0, 0);
    chk("rst_err_overflow", err0, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && i0.ev_valid && i0.ev_ready) begin
      if (sb.size() == 0) chk("unexpected_event", i0.ev_data, 0 - 1);
      else chk("event", i0.ev_data, sb.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    add(8'h1C, 1, ev(0,0,0,0,0,8'h61,8'h1C), 1, 9'h01C, 1);
    add(8'hF0, 0, 0,                         1, 9'h01C, 1);
    add(8'h1C, 1, ev(0,1,0,0,0,8'h61,8'h1C), 0, 9'h01C, 1);
    add(8'h12, 1, ev(0,0,0,0,0,8'h00,8'h12), 0, 9'h01C, 1);
    add(8'h1C, 1, ev(0,0,0,0,1,8'h41,8'h1C), 1, 9'h01C, 2);
    add(8'hF0, 0, 0,                         1, 9'h01C, 2);
    add(8'h1C, 1, ev(0,1,0,0,1,8'h41,8'h1C), 0, 9'h01C, 2);
    add(8'hF0, 0, 0,                         0, 9'h01C, 2);
    add(8'h12, 1, ev(0,1,0,0,1,8'h00,8'h12), 0, 9'h01C, 2);
    add(8'hE0, 0, 0,                         0, 9'h01C, 2);
    add(8'h75, 1, ev(0,0,1,0,0,8'h00,8'h75), 1, 9'h175, 3);
    add(8'hE0, 0, 0,                         1, 9'h175, 3);
    add(8'hF0, 0, 0,                         1, 9'h175, 3);
    add(8'h75, 1, ev(0,1,1,0,0,8'h00,8'h75), 0, 9'h175, 3);
    add(8'h58, 1, ev(0,0,0,0,0,8'h00,8'h58), 0, 9'h175, 3);
    add(8'h1C, 1, ev(0,0,0,1,0,8'h41,8'h1C), 1, 9'h01C, 4);
    add(8'h1C, 0, 0,                         1, 9'h01C, 4);
    add(8'h1C, 0, 0,                         1, 9'h01C, 4);
    add(8'hF0, 0, 0,                         1, 9'h01C, 4);
    add(8'h1C, 1, ev(0,1,0,1,0,8'h41,8'h1C), 0, 9'h01C, 4);
    add(8'h12, 1, ev(0,0,0,1,0,8'h00,8'h12), 0, 9'h01C, 4);
    add(8'h1C, 1, ev(0,0,0,1,1,8'h61,8'h1C), 1, 9'h01C, 5);
    add(8'h45, 1, ev(0,0,0,1,1,8'h30,8'h45), 1, 9'h045, 6);
    add(8'h29, 1, ev(0,0,0,1,1,8'h20,8'h29), 1, 9'h029, 7);
    add(8'h5A, 1, ev(0,0,0,1,1,8'h0D,8'h5A), 1, 9'h05A, 8);
    add(8'hAA, 0, 0,                         1, 9'h05A, 8);
    add(8'h16, 1, ev(0,0,0,1,1,8'h31,8'h16), 1, 9'h016, 9);
    add(8'h58, 1, ev(0,0,0,1,1,8'h00,8'h58), 1, 9'h016, 9);
    add(8'hF0, 0, 0,                         1, 9'h016, 9);
    add(8'h58, 1, ev(0,1,0,0,1,8'h00,8'h58), 1, 9'h016, 9);
    add(8'hF0, 0, 0,                         1, 9'h016, 9);
    add(8'h59, 1, ev(0,1,0,0,1,8'h00,8'h59), 1, 9'h016, 9);
    add(8'h32, 1, ev(0,0,0,0,0,8'h62,8'h32), 1, 9'h032, 10);

    {i0.kb_data, i0.kb_ready, i0.kb_overflow, i0.ev_ready} = '0;
    {i1.kb_data, i1.kb_ready, i1.kb_overflow, i1.ev_ready} = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b0;
    i0.ev_ready = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].p) sb.push_back(tv[i].e);
      send(0, tv[i].b, 0);
      chk("key_held", held0, tv[i].h);
      chk("held_code", hc0, tv[i].c);
      chk("press_count", pc0, tv[i].n);
    end
    drain();

    // FIFO of 4 with the consumer stalled: two of six events must be dropped
    i0.ev_ready = 1'b0;
    sb.push_back(ev(0,0,0,0,0,8'h61,8'h1C));
    sb.push_back(ev(0,0,0,0,0,8'h62,8'h32));
    sb.push_back(ev(0,0,0,0,0,8'h63,8'h21));
    sb.push_back(ev(0,0,0,0,0,8'h64,8'h23));
    send(0, 8'h1C, 0); send(0, 8'h32, 0); send(0, 8'h21, 0);
    send(0, 8'h23, 0); send(0, 8'h24, 0); send(0, 8'h2B, 0);
    chk("full_drop_count", dc0, 2);
    chk("full_ev_valid", i0.ev_valid, 1);
    chk("full_press_count", pc0, 16);
    i0.ev_ready = 1'b1;
    drain();
    chk("emptied_ev_valid", i0.ev_valid, 0);

    send(0, 8'hE0, 0);
    send(0, 8'h75, 1);
    chk("ovf_err", err0, 1);
    chk("ovf_no_event", i0.ev_valid, 0);
    sb.push_back(ev(0,0,0,0,0,8'h61,8'h1C));
    send(0, 8'h1C, 0);
    chk("ovf_held_code", hc0, 9'h01C);
    chk("ovf_press_count", pc0, 17);
    drain();

    // leave a pending event, shift held and a half prefix, then reset
    i0.ev_ready = 1'b0;
    send(0, 8'h32, 0);
    send(0, 8'h12, 0);
    send(0, 8'hE0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset();
    i0.ev_ready = 1'b1;
    sb.push_back(ev(0,0,0,0,0,8'h61,8'h1C));
    send(0, 8'h1C, 0);
    drain();
    chk("post_rst_press_count", pc0, 1);
    chk("post_rst_held_code", hc0, 9'h01C);

    send(1, 8'h1C, 0); send(1, 8'h1C, 0); send(1, 8'h1C, 0);
    chk("rpt_press_count", pc1, 1);
    for (int k = 0; k < 3; k++) begin
      chk("rpt_ev_valid", i1.ev_valid, 1);
      chk("rpt_event", i1.ev_data, ev(k != 0, 0, 0, 0, 0, 8'h61, 8'h1C));
      i1.ev_ready = 1'b1;
      @(posedge clk); #1;
      i1.ev_ready = 1'b0;
    end
    chk("rpt_empty", i1.ev_valid, 0);
    chk("rpt_drop_count", dc1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
